bv4_mul_dom: RTL and testbench

//  d-share masked GF(2^4) multiplier (Domain-Oriented Masking, DOM-indep) for the masked S-box inversion.

---
 rtl/bv4_mul_dom_pkg.sv | 43 ++++
 rtl/bv4_mul_dom_if.sv | 31 +++
 rtl/bv4_mul_dom_term.sv | 30 +++
 rtl/bv4_mul_dom.sv | 96 +++++++++
 tb/tb_bv4_mul_dom.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bv4_mul_dom_pkg.sv
// bv4_mul_dom_pkg
//   Shared types and helpers for the masked GF(2^4) gadgets.
//   bv4_t is a GF(2^4) element in the tower normal basis (GF(2^2) normal
//   basis {W^2,W}, GF(2^4) normal basis {Z^4,Z}); the unit element is 4'hF.
//   dom_num_rand / dom_pair_index give the fresh-randomness word count and the
//   r_ij -> word mapping used by every DOM gadget (bv2/bv4/bv8).
package bv4_mul_dom_pkg;

  typedef logic [1:0] bv2_t;
  typedef logic [3:0] bv4_t;

  // GF(2^2) product, normal basis {W^2,W}.
  function automatic bv2_t bv2_mul(input bv2_t a, input bv2_t b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  // Scale by N = W^2: N*(a1 W^2 + a0 W) = a0 W^2 + (a1^a0) W.
  function automatic bv2_t bv2_scl_n(input bv2_t a);
    return {a[0], a[1] ^ a[0]};
  endfunction

  // GF(2^4) product over GF(2^2), normal basis {Z^4,Z}, Z^2 + Z + N = 0.
  function automatic bv4_t bv4_mul(input bv4_t a, input bv4_t b);
    bv2_t e;
    e = bv2_scl_n(bv2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {bv2_mul(a[3:2], b[3:2]) ^ e, bv2_mul(a[1:0], b[1:0]) ^ e};
  endfunction

  function automatic int dom_num_rand(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Row-major index of unordered pair {i,j}, i!=j: (0,1),(0,2)..(0,d-1),(1,2)..
  function automatic int dom_pair_index(input int i, input int j, input int d);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/bv4_mul_dom_if.sv
// bv4_mul_dom_if
//   Operand/result bundle of the masked bv4 multiplier.
//   master: drives in_a, in_b, in_random, in_valid, in_stall; sees out_c, out_valid.
//   slave : the multiplier side.
//   Share i of an operand is in_a[i]; randomness word k serves pair k of
//   dom_pair_index. NUM_SHARES must match the multiplier instance.
interface bv4_mul_dom_if
  import bv4_mul_dom_pkg::*;
#(
  parameter int NUM_SHARES = 2
);
  localparam int NUM_RAND = dom_num_rand(NUM_SHARES);

  logic [NUM_SHARES-1:0][3:0] in_a;
  logic [NUM_SHARES-1:0][3:0] in_b;
  logic [NUM_RAND-1:0][3:0]   in_random;
  logic                       in_valid;
  logic                       in_stall;
  logic [NUM_SHARES-1:0][3:0] out_c;
  logic                       out_valid;

  modport master (
    output in_a, in_b, in_random, in_valid, in_stall,
    input  out_c, out_valid
  );

  modport slave (
    input  in_a, in_b, in_random, in_valid, in_stall,
    output out_c, out_valid
  );
endinterface

// File: rtl/bv4_mul_dom_term.sv
// bv4_mul_dom_term
//   One registered DOM product term: q <= (a*b) ^ r when en, cleared by rst.
//   Domain terms tie r to zero. The register is the glitch barrier: nothing
//   from another domain is XORed in before it.
//   Ports: clk, rst (sync, high), en, a, b, r (bv4_t in), q (bv4_t out).
module bv4_mul_dom_term
  import bv4_mul_dom_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  bv4_t a,
  input  bv4_t b,
  input  bv4_t r,
  output bv4_t q
);
  bv4_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = bv4_mul(a, b) ^ r;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/bv4_mul_dom.sv
// bv4_mul_dom
//   d-share DOM-indep masked GF(2^4) multiplier. Stage 1 registers every
//   a_i*b_j term (cross terms refreshed with r_ij); share c_i is then the XOR
//   of row i of registered terms. XOR of out_c equals (XOR a)*(XOR b).
//   Ports: in_clock, in_reset (sync, active high, wins over stall),
//          bus (slave modport: in_a, in_b, in_random, in_valid, in_stall,
//          out_c, out_valid).
//   Macro BV4_MUL_DOM_OUT_REG_EN: register the compressed shares (latency 2);
//   otherwise out_c is combinational from stage 1 (latency 1).
//   Data registers load regardless of in_valid; only in_stall holds them.
module bv4_mul_dom
  import bv4_mul_dom_pkg::*;
#(
  parameter int NUM_SHARES = 2
)(
  input logic          in_clock,
  input logic          in_reset,
  bv4_mul_dom_if.slave bus
);
  logic en;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][3:0] term_q;
  logic [NUM_SHARES-1:0][3:0] c_comb;
  logic valid_q, valid_d;

  assign en = !bus.in_stall;

  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
      bv4_t rnd;
      if (i == j) begin : g_dom
        assign rnd = '0;
      end else begin : g_cross
        localparam int K = dom_pair_index(i, j, NUM_SHARES);
        // Same word on both sides of the pair so it cancels in the unmasked sum.
        assign rnd = bus.in_random[K];
      end
      bv4_mul_dom_term u_term (
        .clk (in_clock),
        .rst (in_reset),
        .en  (en),
        .a   (bus.in_a[i]),
        .b   (bus.in_b[j]),
        .r   (rnd),
        .q   (term_q[i][j])
      );
    end
  end

  // Compression touches registered terms only.
  always_comb begin
    for (int i = 0; i < NUM_SHARES; i++) begin
      c_comb[i] = '0;
      for (int j = 0; j < NUM_SHARES; j++) c_comb[i] = c_comb[i] ^ term_q[i][j];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (en) valid_d = bus.in_valid;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) valid_q <= 1'b0;
    else          valid_q <= valid_d;
  end

`ifdef BV4_MUL_DOM_OUT_REG_EN
  logic [NUM_SHARES-1:0][3:0] c_q, c_d;
  logic valid2_q, valid2_d;

  always_comb begin
    c_d      = c_q;
    valid2_d = valid2_q;
    if (en) begin
      c_d      = c_comb;
      valid2_d = valid_q;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      c_q      <= '0;
      valid2_q <= 1'b0;
    end else begin
      c_q      <= c_d;
      valid2_q <= valid2_d;
    end
  end

  assign bus.out_c     = c_q;
  assign bus.out_valid = valid2_q;
`else
  assign bus.out_c     = c_comb;
  assign bus.out_valid = valid_q;
`endif
endmodule

// File: tb/tb_bv4_mul_dom.sv
// tb_bv4_mul_dom
//   Bench for bv4_mul_dom with d=2 and d=3 instances. A scoreboard per
//   instance queues the unmasked golden product whenever an operation is
//   accepted and compares the XOR of out_c when out_valid advances.
//   The golden GF(2^4) model uses discrete logs in GF(2^2).
//   Honours BV4_MUL_DOM_OUT_REG_EN for the expected latency.
module tb_bv4_mul_dom;
`ifdef BV4_MUL_DOM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] q2[$];
  logic [3:0] q3[$];
  logic adv2 = 1'b0;
  logic adv3 = 1'b0;

  always #5 clk = ~clk;

  bv4_mul_dom_if #(.NUM_SHARES(2)) if2 ();
  bv4_mul_dom_if #(.NUM_SHARES(3)) if3 ();

  bv4_mul_dom #(.NUM_SHARES(2)) dut2 (.in_clock(clk), .in_reset(rst), .bus(if2));
  bv4_mul_dom #(.NUM_SHARES(3)) dut3 (.in_clock(clk), .in_reset(rst), .bus(if3));

  // ---- golden model: GF(2^2) via logs of W (01=W, 10=W^2, 11=1) ----
  function automatic int lg2(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] ex2(input int e);
    case (e)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] g2(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return ex2((lg2(a) + lg2(b)) % 3);
  endfunction

  function automatic logic [3:0] g4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] e;
    e = g2(g2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), 2'b10);
    return {g2(a[3:2], b[3:2]) ^ e, g2(a[1:0], b[1:0]) ^ e};
  endfunction

  function automatic logic [3:0] ux2(input logic [1:0][3:0] s);
    return s[0] ^ s[1];
  endfunction

  function automatic logic [3:0] ux3(input logic [2:0][3:0] s);
    return s[0] ^ s[1] ^ s[2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- scoreboards ----
  always @(posedge clk) begin
    adv2 = !rst && !if2.in_stall;
    adv3 = !rst && !if3.in_stall;
    if (rst) begin
      q2.delete();
      q3.delete();
    end else begin
      if (!if2.in_stall && if2.in_valid) q2.push_back(g4(ux2(if2.in_a), ux2(if2.in_b)));
      if (!if3.in_stall && if3.in_valid) q3.push_back(g4(ux3(if3.in_a), ux3(if3.in_b)));
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (adv2 && if2.out_valid) begin
      if (q2.size() == 0) chk("sb2_underflow", 32'(q2.size() != 0), 32'd1);
      else begin
        e = q2.pop_front();
        chk("sb2_c", 32'(ux2(if2.out_c)), 32'(e));
      end
    end
    if (adv3 && if3.out_valid) begin
      if (q3.size() == 0) chk("sb3_underflow", 32'(q3.size() != 0), 32'd1);
      else begin
        e = q3.pop_front();
        chk("sb3_c", 32'(ux3(if3.out_c)), 32'(e));
      end
    end
  end

  // ---- directed sequence ----
  initial begin
    logic [1:0][3:0] snap_c;
    logic            snap_v;
    logic [3:0]      za, zb;

    rst = 1'b1;
    if2.in_a = '0; if2.in_b = '0; if2.in_random = '0; if2.in_valid = 1'b0; if2.in_stall = 1'b0;
    if3.in_a = '0; if3.in_b = '0; if3.in_random = '0; if3.in_valid = 1'b0; if3.in_stall = 1'b0;
    tick(); tick();
    chk("rst_valid2", 32'(if2.out_valid), 32'd0);
    chk("rst_c2",     32'(if2.out_c),     32'd0);
    chk("rst_valid3", 32'(if3.out_valid), 32'd0);
    chk("rst_c3",     32'(if3.out_c),     32'd0);
    rst = 1'b0;
    tick();
    chk("idle_valid2", 32'(if2.out_valid), 32'd0);

    // 1: A = F (unit) as {3,C}, B = 6 as {5,3}, r = A
    if2.in_a = {4'hC, 4'h3};
    if2.in_b = {4'h3, 4'h5};
    if2.in_random = 4'hA;
    if2.in_valid = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1) if2.in_valid = 1'b0;
      chk("t1_latency", 32'(if2.out_valid), 32'(k == LAT));
    end
    chk("t1_c", 32'(ux2(if2.out_c)), 32'h6);

    // 2: A = 0 as {9,9}, every randomness value
    for (int r = 0; r < 16; r++) begin
      if2.in_a = {4'h9, 4'h9};
      if2.in_b = 8'($urandom);
      if2.in_random = 4'(r);
      if2.in_valid = 1'b1;
      tick();
    end
    // random d=2 vectors
    for (int n = 0; n < 32; n++) begin
      if2.in_a = 8'($urandom);
      if2.in_b = 8'($urandom);
      if2.in_random = 4'($urandom);
      tick();
    end
    if2.in_valid = 1'b0;
    repeat (LAT) tick();

    // 4: stall freezes outputs; post-stall result is the first post-stall op
    if2.in_a = 8'($urandom); if2.in_b = 8'($urandom); if2.in_random = 4'($urandom);
    if2.in_valid = 1'b1;
    tick();
    snap_c = if2.out_c;
    snap_v = if2.out_valid;
    if2.in_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if2.in_a = 8'($urandom); if2.in_b = 8'($urandom); if2.in_random = 4'($urandom);
      tick();
      chk("t4_stall_c", 32'(if2.out_c),     32'(snap_c));
      chk("t4_stall_v", 32'(if2.out_valid), 32'(snap_v));
    end
    if2.in_stall = 1'b0;
    za = 4'($urandom); zb = 4'($urandom);
    if2.in_a = {za ^ 4'h5, 4'h5};
    if2.in_b = {zb ^ 4'hE, 4'hE};
    if2.in_random = 4'($urandom);
    tick();
    if2.in_valid = 1'b0;
    repeat (LAT - 1) tick();
    chk("t4_post_v", 32'(if2.out_valid), 32'd1);
    chk("t4_post_c", 32'(ux2(if2.out_c)), 32'(g4(za, zb)));
    repeat (LAT) tick();

    // 5: reset with operations in flight
    if2.in_a = 8'($urandom); if2.in_b = 8'($urandom); if2.in_random = 4'($urandom);
    if2.in_valid = 1'b1;
    tick();
    if2.in_a = 8'($urandom); if2.in_b = 8'($urandom);
    rst = 1'b1;
    tick();
    chk("t5_rst_v", 32'(if2.out_valid), 32'd0);
    chk("t5_rst_c", 32'(if2.out_c),     32'd0);
    rst = 1'b0;
    if2.in_valid = 1'b0;
    repeat (LAT + 1) tick();
    chk("t5_idle_v", 32'(if2.out_valid), 32'd0);

    // 3: d=3 back-to-back random stream
    if3.in_valid = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if3.in_a = 12'($urandom);
      if3.in_b = 12'($urandom);
      if3.in_random = 12'($urandom);
      tick();
      if (n >= LAT - 1 && (n % 500) == 0) chk("t3_valid_cont", 32'(if3.out_valid), 32'd1);
    end
    if3.in_valid = 1'b0;
    repeat (LAT + 1) tick();
    chk("t3_drain_v", 32'(if3.out_valid), 32'd0);

    chk("sb2_empty", 32'(q2.size()), 32'd0);
    chk("sb3_empty", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
